// File: rtl/seg7_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_pkg : shared constants and hex decode table for the 8-digit scanner
// Revision : 1.0
// ----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; packed list runs from F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode : combinational nibble to active-low segment pattern
// Revision    : 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_scanner : double-buffered 8-digit multiplexed hex display driver
// Revision     : 1.0
// ----------------------------------------------------------------------------
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_mask,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned      CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [31:0]      r_pend_val;
  logic [7:0]       r_pend_dp;
  logic             r_pend_vld;
  logic [31:0]      r_shadow_val;
  logic [7:0]       r_shadow_dp;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;

  logic             w_cnt_wrap;
  logic             w_frame_edge;
  logic [31:0]      w_upper;
  logic             w_blank;
  logic [6:0]       w_seg_dec;
  logic [7:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  assign w_cnt_wrap   = (r_cnt == CNT_MAX);
  assign w_frame_edge = w_cnt_wrap && (r_idx == LAST_DIGIT);

  // Current digit sits in the low nibble; anything left above it decides blanking.
  assign w_upper = r_shadow_val >> {r_idx, 2'b00};

  seg7_decode u_decode (
    .nibble (w_upper[3:0]),
    .seg    (w_seg_dec)
  );

  always_comb begin
    w_blank   = blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);
    w_an_nxt  = ~(8'd1 << r_idx);
    w_seg_nxt = w_seg_dec;
    w_dp_nxt  = ~r_shadow_dp[r_idx];
    if (w_blank) begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load on the boundary edge stays pending: the transfer uses the old pend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_val   <= 32'd0;
      r_pend_dp    <= 8'd0;
      r_pend_vld   <= 1'b0;
      r_shadow_val <= 32'd0;
      r_shadow_dp  <= 8'd0;
    end else begin
      if (w_frame_edge && r_pend_vld) begin
        r_shadow_val <= r_pend_val;
        r_shadow_dp  <= r_pend_dp;
      end
      if (load) begin
        r_pend_val <= data_in;
        r_pend_dp  <= dp_mask;
        r_pend_vld <= 1'b1;
      end else if (w_frame_edge) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= w_an_nxt;
      seg        <= w_seg_nxt;
      dp         <= w_dp_nxt;
      frame_done <= w_frame_edge;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg7_scanner : directed self-checking bench for seg7_scanner (SCAN_DIV=4)
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_seg7_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  dp_mask;
  logic        load;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scanner #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_mask    (dp_mask),
    .load       (load),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] val, input logic [7:0] dpm);
    data_in = val;
    dp_mask = dpm;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  // Advance until frame_done is seen (bounded); leaves time just after that edge.
  task automatic wait_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (frame_done === 1'b1) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  // Starting just after a frame boundary edge, check all 32 cycles of one frame.
  task automatic check_frame(input logic [31:0] val, input logic [7:0] dpm,
                             input logic blk, input string tag);
    logic [31:0] upper;
    logic        blanked;
    logic        fd;
    logic [16:0] exp;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        upper   = val >> (4 * d);
        blanked = blk && (d != 0) && (upper == 32'd0);
        fd      = (d == 7) && (c == 3);
        if (blanked) exp = {8'hFF, 7'h7F, 1'b1, fd};
        else         exp = {8'(~(8'd1 << d)), hexseg(upper[3:0]), ~dpm[d], fd};
        chk(tag, {15'd0, an, seg, dp, frame_done}, {15'd0, exp});
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    data_in  = 32'd0;
    dp_mask  = 8'd0;
    load     = 1'b0;
    blank_lz = 1'b0;

    step(3);
    chk("rst_an",  {24'd0, an},  32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp",  {31'd0, dp},  32'd1);
    chk("rst_fd",  {31'd0, frame_done}, 32'd0);

    rst = 1'b1;
    step(1);
    chk("first_digit", {15'd0, an, seg, dp, frame_done}, {15'd0, 8'hFE, 7'b1000000, 1'b1, 1'b0});

    for (int e = 2; e <= 64; e++) begin
      step(1);
      chk("scan_timing", {23'd0, an, frame_done},
          {23'd0, 8'(~(8'd1 << (((e - 1) / 4) % 8))), 1'(e % 32 == 0)});
    end

    do_load(32'h12345678, 8'h81);
    wait_frame("wait_load");
    check_frame(32'h12345678, 8'h81, 1'b0, "load_display");

    step(13);
    chk("at_digit3", {24'd0, an}, 32'hF7);
    do_load(32'hAAAAAAAA, 8'h00);
    step(7);
    chk("at_digit5", {24'd0, an}, 32'hDF);
    do_load(32'h55555555, 8'h00);
    wait_frame("wait_tear");
    check_frame(32'h55555555, 8'h00, 1'b0, "no_tearing");

    step(31);
    do_load(32'h9ABCDEF0, 8'h0F);
    chk("boundary_fd", {31'd0, frame_done}, 32'd1);
    check_frame(32'h55555555, 8'h00, 1'b0, "boundary_hold");
    check_frame(32'h9ABCDEF0, 8'h0F, 1'b0, "boundary_next");

    blank_lz = 1'b1;
    do_load(32'h000000A5, 8'hFF);
    wait_frame("wait_blank_a5");
    check_frame(32'h000000A5, 8'hFF, 1'b1, "blank_a5");
    do_load(32'h00000000, 8'h00);
    wait_frame("wait_blank_0");
    check_frame(32'h00000000, 8'h00, 1'b1, "blank_zero");

    blank_lz = 1'b0;
    do_load(32'h11111111, 8'hFF);
    step(20);
    chk("pre_reset_digit5", {24'd0, an}, 32'hDF);
    rst = 1'b0;
    #1;
    chk("async_rst", {15'd0, an, seg, dp, frame_done}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    step(2);
    rst = 1'b1;
    check_frame(32'h00000000, 8'h00, 1'b0, "post_reset");
    check_frame(32'h00000000, 8'h00, 1'b0, "post_reset_nopend");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
